// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame sequencer for BM/ACS enables, survivor writes, normalization and traceback
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN   = 64,
    parameter int NORM_PERIOD = 16,
    parameter int ST_W        = 8,
    parameter int AW          = $clog2(FRAME_LEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_sym_valid,
    output logic            o_sym_ready,
    output logic            o_en_bm,
    output logic            o_en_acs,
    output logic            o_norm,
    output logic            o_surv_we,
    output logic [AW-1:0]   o_surv_addr,
    input  logic [ST_W-1:0] i_sel_node,
    output logic            o_tb_load,
    output logic [ST_W-1:0] o_tb_start_st,
    output logic            o_tb_en,
    output logic [AW-1:0]   o_tb_addr,
    input  logic            i_out_ready,
    output logic            o_busy,
    output logic            o_done
);
    localparam int NW = $clog2(NORM_PERIOD) + 1;
    localparam logic [AW:0]   STEP_LAST = (AW+1)'(FRAME_LEN - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(FRAME_LEN - 1);
    localparam logic [NW-1:0] NORM_LAST = NW'(NORM_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, ACQ, DRAIN, SEL, TB, DONE} state_e;

    state_e            state_q, state_d;
    logic [AW:0]       step_q, step_d;
    logic [NW-1:0]     norm_cnt_q, norm_cnt_d;
    logic              drain_q, drain_d;
    logic              en_bm_q, en_bm_d;
    logic [AW-1:0]     bm_addr_q, bm_addr_d;
    logic              en_acs_q, en_acs_d;
    logic              norm_q, norm_d;
    logic [AW-1:0]     surv_addr_q, surv_addr_d;
    logic [AW-1:0]     tb_addr_q, tb_addr_d;
    logic [ST_W-1:0]   tb_start_q, tb_start_d;
    logic              accept, tb_en;

    assign accept = state_q == ACQ && i_sym_valid;
    assign tb_en  = state_q == TB && i_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            norm_cnt_q  <= '0;
            drain_q     <= 1'b0;
            en_bm_q     <= 1'b0;
            bm_addr_q   <= '0;
            en_acs_q    <= 1'b0;
            norm_q      <= 1'b0;
            surv_addr_q <= '0;
            tb_addr_q   <= '0;
            tb_start_q  <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            norm_cnt_q  <= norm_cnt_d;
            drain_q     <= drain_d;
            en_bm_q     <= en_bm_d;
            bm_addr_q   <= bm_addr_d;
            en_acs_q    <= en_acs_d;
            norm_q      <= norm_d;
            surv_addr_q <= surv_addr_d;
            tb_addr_q   <= tb_addr_d;
            tb_start_q  <= tb_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        norm_cnt_d  = en_bm_q ? (norm_cnt_q == NORM_LAST ? '0 : norm_cnt_q + NW'(1)) : norm_cnt_q;
        drain_d     = state_q == DRAIN && !drain_q;
        en_bm_d     = accept;
        bm_addr_d   = accept ? step_q[AW-1:0] : bm_addr_q;
        en_acs_d    = en_bm_q;
        norm_d      = en_bm_q && norm_cnt_q == NORM_LAST;
        surv_addr_d = en_bm_q ? bm_addr_q : surv_addr_q;
        tb_addr_d   = tb_addr_q;
        tb_start_d  = tb_start_q;
        case (state_q)
            IDLE: if (i_start) begin
                state_d    = ACQ;
                step_d     = '0;
                norm_cnt_d = '0;
            end
            ACQ: if (accept) begin
                step_d  = step_q + (AW+1)'(1);
                state_d = step_q == STEP_LAST ? DRAIN : ACQ;
            end
            DRAIN: state_d = drain_q ? SEL : DRAIN;
            SEL: begin
                tb_start_d = i_sel_node;
                tb_addr_d  = ADDR_LAST;
                state_d    = TB;
            end
            TB: if (tb_en) begin
                state_d   = tb_addr_q == '0 ? DONE : TB;
                tb_addr_d = tb_addr_q == '0 ? tb_addr_q : tb_addr_q - AW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_sym_ready   = state_q == ACQ;
    assign o_en_bm       = en_bm_q;
    assign o_en_acs      = en_acs_q;
    assign o_norm        = norm_q;
    assign o_surv_we     = en_acs_q;
    assign o_surv_addr   = surv_addr_q;
    assign o_tb_load     = state_q == SEL;
    assign o_tb_start_st = tb_start_q;
    assign o_tb_en       = tb_en;
    assign o_tb_addr     = tb_addr_q;
    assign o_busy        = state_q != IDLE;
    assign o_done        = state_q == DONE;
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: scoreboard bench for viterbi_frame_ctrl with FRAME_LEN=8, NORM_PERIOD=4
module tb_viterbi_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_sym_valid = 1'b0;
    logic       o_sym_ready, o_en_bm, o_en_acs, o_norm, o_surv_we;
    logic [2:0] o_surv_addr;
    logic [7:0] i_sel_node = 8'h00;
    logic       o_tb_load;
    logic [7:0] o_tb_start_st;
    logic       o_tb_en;
    logic [2:0] o_tb_addr;
    logic       i_out_ready = 1'b0;
    logic       o_busy, o_done;

    viterbi_frame_ctrl #(.FRAME_LEN(8), .NORM_PERIOD(4)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_sym_valid(i_sym_valid),
        .o_sym_ready(o_sym_ready), .o_en_bm(o_en_bm), .o_en_acs(o_en_acs),
        .o_norm(o_norm), .o_surv_we(o_surv_we), .o_surv_addr(o_surv_addr),
        .i_sel_node(i_sel_node), .o_tb_load(o_tb_load), .o_tb_start_st(o_tb_start_st),
        .o_tb_en(o_tb_en), .o_tb_addr(o_tb_addr), .i_out_ready(i_out_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] addr;
        logic       norm;
    } acs_t;

    int         checks = 0;
    int         fails = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         tb_cnt = 0;
    int         load_cnt = 0;
    logic [7:0] exp_start = 8'h00;
    int         bm_q[$];
    acs_t       acs_q[$];
    int         tb_q[$];
    acs_t       e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_en_bm) begin
                if (bm_q.size() == 0) chk("bm_extra", o_en_bm, 0);
                else chk("bm_cycle", cyc, bm_q.pop_front());
            end
            if (o_en_acs) begin
                if (acs_q.size() == 0) chk("acs_extra", o_en_acs, 0);
                else begin
                    e = acs_q.pop_front();
                    chk("acs_cycle", cyc, e.cyc);
                    chk("surv_addr", o_surv_addr, e.addr);
                    chk("norm", o_norm, e.norm);
                end
            end
            if (o_surv_we || o_en_acs || o_norm) chk("surv_we_vs_acs", o_surv_we, o_en_acs);
            if (o_norm && !o_en_acs) chk("norm_outside_acs", o_norm, 0);
            if (o_tb_en) begin
                if (tb_q.size() == 0) chk("tb_extra", o_tb_en, 0);
                else chk("tb_addr", o_tb_addr, tb_q.pop_front());
                chk("tb_start_st", o_tb_start_st, exp_start);
                tb_cnt++;
            end
            if (o_tb_load) load_cnt++;
            if (o_done) done_cnt++;
        end
    end

    task automatic run_frame(input int mode, input logic [7:0] node, input bit bp,
                             input bit ign, input int abort_at);
        int acc, k, d0, t0, l0, stall;
        acc = 0; k = 0; stall = 0;
        d0 = done_cnt; t0 = tb_cnt; l0 = load_cnt;
        i_sel_node = node;
        exp_start = node;
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        while (acc < 8 && k < 100) begin
            i_sym_valid = (mode == 0) || (k % 3 == 0);
            i_start = ign && acc == 3;
            @(negedge clk);
            if (i_sym_valid && o_sym_ready) begin
                bm_q.push_back(cyc + 1);
                acs_q.push_back('{cyc + 2, 3'(acc), (acc % 4 == 3)});
                acc++;
            end
            k++;
            @(posedge clk); #1;
            if (abort_at != 0 && acc == abort_at) begin
                rst = 1'b1;
                i_sym_valid = 1'b0;
                i_start = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("abort_outputs", {o_sym_ready, o_en_bm, o_en_acs, o_norm, o_surv_we, o_surv_addr,
                     o_tb_load, o_tb_start_st, o_tb_en, o_tb_addr, o_busy, o_done}, 0);
                bm_q.delete();
                acs_q.delete();
                rst = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                chk("abort_no_done", done_cnt - d0, 0);
                chk("abort_idle", o_busy, 0);
                return;
            end
        end
        i_start = 1'b0;
        chk("accept_count", acc, 8);
        i_sym_valid = 1'b1;
        @(negedge clk);
        chk("ready_after_last", o_sym_ready, 0);
        for (int a = 7; a >= 0; a--) tb_q.push_back(a);
        i_sym_valid = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            @(posedge clk); #1;
            i_start = ign && (tb_cnt - t0 == 2);
            if (bp && tb_cnt - t0 == 3 && stall < 3) begin
                i_out_ready = 1'b0;
                stall++;
            end else i_out_ready = 1'b1;
            @(negedge clk);
            if (!i_out_ready) begin
                chk("stall_tb_en", o_tb_en, 0);
                chk("stall_tb_addr", o_tb_addr, 4);
            end
            k++;
        end
        i_start = 1'b0;
        chk("done_seen", done_cnt - d0, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("tb_en_count", tb_cnt - t0, 8);
        chk("tb_load_count", load_cnt - l0, 1);
        chk("idle_after_done", o_busy, 0);
        chk("start_st_hold", o_tb_start_st, node);
        chk("queues_drained", bm_q.size() + acs_q.size() + tb_q.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {o_sym_ready, o_en_bm, o_en_acs, o_norm, o_surv_we, o_surv_addr,
             o_tb_load, o_tb_start_st, o_tb_en, o_tb_addr, o_busy, o_done}, 0);
        rst = 1'b0;
        run_frame(0, 8'hA5, 0, 0, 0);
        run_frame(1, 8'h3C, 1, 0, 0);
        run_frame(0, 8'h5A, 0, 1, 0);
        run_frame(0, 8'h11, 0, 0, 5);
        run_frame(0, 8'h81, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
Frame-level sequencer for the radix-4 Viterbi decoder. It accepts received symbols over a valid/ready handshake and pipelines the enables to the branch-metric unit and the add-compare-select unit. It generates survivor-memory write addresses, issues periodic path-metric normalization pulses, and captures the ACS best-node index at end of frame. It then drives the traceback unit backwards through survivor memory with output back-pressure.

Parameters:
FRAME_LEN, 64, trellis steps (symbols) per frame; must be ≥ 2.
NORM_PERIOD, 16, ACS steps between normalization pulses; must be ≥ 1.
ST_W, 8, state index width (256 states).
AW, $clog2(FRAME_LEN), survivor/traceback address width.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
i_start  in  1  frame start pulse; honoured only in IDLE
i_sym_valid  in  1  upstream symbol valid
o_sym_ready  out  1  controller accepts a symbol this cycle
o_en_bm  out  1  branch-metric enable, one cycle per accepted symbol
o_en_acs  out  1  ACS enable, one cycle per accepted symbol
o_norm  out  1  path-metric normalization pulse, coincident with o_en_acs
o_surv_we  out  1  survivor memory write strobe
o_surv_addr  out  AW  survivor write address (trellis step index)
i_sel_node  in  ST_W  best-metric state from ACS
o_tb_load  out  1  one-cycle pulse: traceback loads o_tb_start_st
o_tb_start_st  out  ST_W  captured start state for traceback
o_tb_en  out  1  traceback step enable
o_tb_addr  out  AW  survivor read address for traceback
i_out_ready  in  1  downstream accepts decoded output
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE. All outputs 0: o_surv_addr, o_tb_addr, o_tb_start_st, and all counters cleared. A reset mid-frame aborts immediately. No o_done is issued.
- States: IDLE, ACQ, DRAIN, SEL, TB, DONE.
- IDLE: i_start=1 → ACQ next cycle, with step_cnt=0 and norm_cnt=0. i_start in any other state is ignored.
- ACQ: o_sym_ready=1 (combinational, state==ACQ). An accept occurs when i_sym_valid && o_sym_ready; step_cnt increments on each accept. When i_sym_valid=0, nothing advances and no enables are issued.
- Enable pipeline (registered):
  - accept at cycle N → o_en_bm=1 at N+1;
  - o_en_acs=1, o_surv_we=1 and o_surv_addr=step index of that symbol (0..FRAME_LEN-1) at N+2.
  - Back-to-back accepts produce back-to-back enables.
- Normalization: norm_cnt counts ACS steps. o_norm=1 on the o_en_acs cycle that completes every NORM_PERIOD-th step (steps NORM_PERIOD-1, 2·NORM_PERIOD-1, ...). norm_cnt wraps to 0 after the pulse.
- Leaving ACQ: the accept with step_cnt==FRAME_LEN-1 → DRAIN next cycle, so o_sym_ready is low in the following cycle.
- DRAIN: stays exactly 2 cycles so the last o_en_acs/o_surv_we is issued. Then → SEL.
- SEL (1 cycle): register o_tb_start_st <= i_sel_node and assert o_tb_load=1; o_tb_addr <= FRAME_LEN-1. → TB.
- TB: o_tb_en = i_out_ready.
  - When o_tb_en=1, o_tb_addr decrements after that cycle.
  - When i_out_ready=0, o_tb_en=0 and o_tb_addr holds.
  - The cycle with o_tb_en=1 and o_tb_addr==0 → DONE next; there is no wrap below 0.
- DONE: o_done=1 for one cycle, then → IDLE. o_tb_start_st keeps its value until the next SEL.
- o_en_bm, o_en_acs, o_surv_we and o_norm are never asserted outside the ACQ/DRAIN pipeline window. o_tb_en and o_tb_load are never asserted outside SEL/TB.
- Counter widths: step_cnt is AW+1 bits; norm_cnt is $clog2(NORM_PERIOD)+1 bits. No overflow is possible within a frame.

Test Plan:
- FRAME_LEN=8, NORM_PERIOD=4; pulse i_start; hold i_sym_valid=1 → exactly 8 accepts.
  - o_en_acs high for 8 consecutive cycles, 2 cycles after each accept, with o_surv_addr 0..7.
  - o_norm high on addr 3 and addr 7; o_sym_ready low from the cycle after the 8th accept.
- Toggle i_sym_valid as 1,0,0,1,...: enables appear only 1/2 cycles after accepted symbols, and addresses stay contiguous 0..7 with no gaps or duplicates.
- Set i_sel_node=8'hA5 during SEL → o_tb_load pulses once and o_tb_start_st=8'hA5. With i_out_ready=1, o_tb_en is high for 8 cycles with o_tb_addr 7..0, then o_done pulses once.
- Traceback back-pressure: drop i_out_ready for 3 cycles at o_tb_addr=4 → o_tb_en=0 and o_tb_addr holds at 4; resume gives 4,3,2,1,0, and the total o_tb_en count is 8.
- i_start asserted during ACQ and TB → ignored: step_cnt is not cleared and no extra frame runs.
- Assert rst at step 5 of ACQ → next cycle all outputs 0, state IDLE, no o_done. A new i_start then runs a full frame from address 0.
